// File: rtl/int_to_float_e4m3.sv
// Signed integer to FP8 E4M3 converter: one normalising shift per clock,
// round-to-nearest-even, saturation to +/-448, valid/ready on both sides.
module int_to_float_e4m3 #(
    parameter int unsigned IN_W = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic            out_sat
);

    localparam int unsigned EXP_W  = 5;
    localparam int unsigned MAN_W  = 3;
    localparam int unsigned EM_W   = EXP_W + MAN_W;
    localparam int unsigned BIAS   = 7;
    localparam logic [EXP_W-1:0] EXP_START = EXP_W'(IN_W - 1 + BIAS);
    // Bits below the guard bit that feed the sticky OR (empty when IN_W=5).
    localparam logic [IN_W-1:0] STICKY_MASK = IN_W'((1 << (IN_W - 5)) - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic             sign_r, sign_nxt;
    logic [IN_W-1:0]  mag_r, mag_nxt;
    logic [EXP_W-1:0] exp_r, exp_nxt;
    logic [7:0]       out_data_nxt;
    logic             out_sat_nxt;
    logic             in_ready_nxt;
    logic             out_valid_nxt;

    logic [MAN_W-1:0] man;
    logic             guard;
    logic             sticky;
    logic             inc;
    logic [EM_W-1:0]  rounded;
    logic [EXP_W-1:0] exp_rnd;
    logic [MAN_W-1:0] man_rnd;
    logic [IN_W-1:0]  in_abs;

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            sign_r    <= 1'b0;
            mag_r     <= '0;
            exp_r     <= '0;
            out_data  <= 8'h00;
            out_sat   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            sign_r    <= sign_nxt;
            mag_r     <= mag_nxt;
            exp_r     <= exp_nxt;
            out_data  <= out_data_nxt;
            out_sat   <= out_sat_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    // Next state, datapath updates and rounding
    always_comb begin
        state_nxt    = state;
        sign_nxt     = sign_r;
        mag_nxt      = mag_r;
        exp_nxt      = exp_r;
        out_data_nxt = out_data;
        out_sat_nxt  = out_sat;

        in_abs  = in_data[IN_W-1] ? (IN_W'(0) - in_data) : in_data;
        man     = mag_r[IN_W-2 -: MAN_W];
        guard   = mag_r[IN_W-5];
        sticky  = |(mag_r & STICKY_MASK);
        inc     = guard & (sticky | man[0]);
        // Mantissa carry ripples straight into the exponent field.
        rounded = {exp_r, man} + EM_W'(inc);
        exp_rnd = rounded[EM_W-1:MAN_W];
        man_rnd = rounded[MAN_W-1:0];

        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_nxt  = in_data[IN_W-1];
                    mag_nxt   = in_abs;
                    exp_nxt   = EXP_START;
                    state_nxt = ST_NORM;
                end
            end
            ST_NORM: begin
                if (mag_r == '0) begin
                    out_data_nxt = 8'h00;
                    out_sat_nxt  = 1'b0;
                    state_nxt    = ST_DONE;
                end else if (mag_r[IN_W-1]) begin
                    state_nxt = ST_ROUND;
                end else begin
                    mag_nxt = mag_r << 1;
                    exp_nxt = exp_r - EXP_W'(1);
                end
            end
            ST_ROUND: begin
                if (exp_rnd > EXP_W'(15) ||
                    (exp_rnd == EXP_W'(15) && man_rnd == MAN_W'(7))) begin
                    out_data_nxt = {sign_r, 7'h7E};
                    out_sat_nxt  = 1'b1;
                end else begin
                    out_data_nxt = {sign_r, exp_rnd[3:0], man_rnd};
                    out_sat_nxt  = 1'b0;
                end
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        in_ready_nxt  = (state_nxt == ST_IDLE);
        out_valid_nxt = (state_nxt == ST_DONE);
    end

endmodule

// File: tb/tb_int_to_float_e4m3.sv
// Directed bench for int_to_float_e4m3 at IN_W=8 and IN_W=16, checked against an
// arithmetic E4M3 encoding model plus hand-computed literal results and latencies.
module tb_int_to_float_e4m3;

    logic        clock;
    logic        reset;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, out_sat8;
    logic [7:0]  in_data8, out_data8;
    logic        in_valid16, in_ready16, out_valid16, out_ready16, out_sat16;
    logic [15:0] in_data16;
    logic [7:0]  out_data16;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] exp8, exp16;
    logic       exp8_vld, exp16_vld;

    int_to_float_e4m3 #(.IN_W(8)) dut8 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_data(out_data8), .out_sat(out_sat8)
    );

    int_to_float_e4m3 #(.IN_W(16)) dut16 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .out_data(out_data16), .out_sat(out_sat16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // E4M3 value of integer v as {sat, code}: scale |v| to 8..15.x, round half-even.
    function automatic logic [8:0] model(input int v);
        longint a, num, den, q, r;
        int     e, ex;
        logic   s;
        s = (v < 0);
        a = s ? -longint'(v) : longint'(v);
        if (a == 0) return 9'h000;
        e = 0;
        while ((longint'(1) << (e + 1)) <= a) e++;
        num = a * 8;
        den = longint'(1) << e;
        q = num / den;
        r = num % den;
        if (2 * r > den || (2 * r == den && q % 2 == 1)) q++;
        if (q == 16) begin q = 8; e++; end
        ex = e + 7;
        if (ex > 15 || (ex == 15 && q == 15)) return {1'b1, s, 7'h7E};
        return {1'b0, s, 4'(ex), 3'(q - 8)};
    endfunction

    function automatic logic ov(input int w);
        return (w == 8) ? out_valid8 : out_valid16;
    endfunction

    function automatic logic rdy(input int w);
        return (w == 8) ? in_ready8 : in_ready16;
    endfunction

    function automatic logic [8:0] res(input int w);
        return (w == 8) ? {out_sat8, out_data8} : {out_sat16, out_data16};
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Compare process: every cycle an output is presented, it must match the model.
    always @(negedge clock) begin
        if (!reset && out_valid8 && exp8_vld) begin
            check("model8", int'({out_sat8, out_data8}), int'(exp8));
            check("busy_ready8", int'(in_ready8), 0);
        end
        if (!reset && out_valid16 && exp16_vld) begin
            check("model16", int'({out_sat16, out_data16}), int'(exp16));
            check("busy_ready16", int'(in_ready16), 0);
        end
    end

    task automatic drive(input int w, input logic vld, input logic [15:0] d);
        if (w == 8) begin in_valid8 = vld; in_data8 = d[7:0]; end
        else begin in_valid16 = vld; in_data16 = d; end
    endtask

    task automatic set_ready(input int w, input logic r);
        if (w == 8) out_ready8 = r; else out_ready16 = r;
    endtask

    task automatic convert(input int w, input logic [15:0] v, input logic [7:0] lit_d,
                           input logic lit_s, input int lit_lat, input int hold);
        int n;
        int vi;
        logic [8:0] m;
        vi = (w == 8) ? int'($signed(v[7:0])) : int'($signed(v));
        m  = model(vi);
        @(negedge clock);
        check("ready_before", int'(rdy(w)), 1);
        if (w == 8) begin exp8 = m; exp8_vld = 1'b1; end
        else begin exp16 = m; exp16_vld = 1'b1; end
        drive(w, 1'b1, v);
        @(posedge clock); #1;
        drive(w, 1'b0, 16'h0);
        n = 0;
        while (!ov(w) && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        check("latency", n, lit_lat);
        check("lit_result", int'(res(w)), int'({lit_s, lit_d}));
        for (int i = 0; i < hold; i++) begin
            drive(w, 1'b1, 16'h0005);
            @(posedge clock); #1;
            check("hold_data", int'(res(w)), int'({lit_s, lit_d}));
            check("hold_valid", int'(ov(w)), 1);
            check("hold_ready", int'(rdy(w)), 0);
        end
        drive(w, 1'b0, 16'h0);
        set_ready(w, 1'b1);
        @(posedge clock); #1;
        set_ready(w, 1'b0);
        if (w == 8) exp8_vld = 1'b0; else exp16_vld = 1'b0;
        check("release_valid", int'(ov(w)), 0);
        check("release_ready", int'(rdy(w)), 1);
    endtask

    initial begin
        reset = 1'b1;
        exp8_vld = 1'b0; exp16_vld = 1'b0;
        exp8 = '0; exp16 = '0;
        in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
        in_valid16 = 1'b0; in_data16 = '0; out_ready16 = 1'b0;
        #12;
        check("rst_valid", int'(out_valid8), 0);
        check("rst_data", int'(out_data8), 0);
        check("rst_sat", int'(out_sat8), 0);
        check("rst_ready", int'(in_ready8), 1);
        check("rst_ready16", int'(in_ready16), 1);
        @(negedge clock);
        reset = 1'b0;

        convert(8, 16'h0001, 8'h38, 1'b0, 9, 0);
        convert(8, 16'h0080, 8'hF0, 1'b0, 2, 0);
        convert(8, 16'h0000, 8'h00, 1'b0, 1, 0);
        convert(8, 16'd19,   8'h5A, 1'b0, 5, 0);
        convert(8, 16'd17,   8'h58, 1'b0, 5, 0);
        convert(8, 16'd127,  8'h70, 1'b0, 3, 0);
        convert(8, 16'h00FF, 8'hB8, 1'b0, 9, 0);
        convert(8, 16'h00ED, 8'hDA, 1'b0, 5, 0);
        convert(8, 16'd19,   8'h5A, 1'b0, 5, 5);

        convert(16, 16'd464,  8'h7E, 1'b0, 9, 0);
        convert(16, 16'd480,  8'h7E, 1'b1, 9, 0);
        convert(16, 16'h7FFF, 8'h7E, 1'b1, 3, 0);
        convert(16, 16'h8000, 8'hFE, 1'b1, 2, 0);
        convert(16, 16'h0001, 8'h38, 1'b0, 17, 0);
        convert(16, 16'hFFFB, 8'hCA, 1'b0, 15, 0);

        // Abort a conversion of 1 while it is still normalising.
        @(negedge clock);
        in_valid8 = 1'b1; in_data8 = 8'h01;
        @(posedge clock); #1;
        in_valid8 = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check("abort_valid", int'(out_valid8), 0);
        check("abort_ready", int'(in_ready8), 1);
        @(negedge clock);
        reset = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        check("abort_no_output", int'(out_valid8), 0);
        convert(8, 16'd5, 8'h4A, 1'b0, 7, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
